// File: rtl/rwq_pkg.sv
// Shared types and constants for the register-file write queue.
package rwq_pkg;
    localparam int RWQ_DEPTH = 4;
    localparam int RWQ_AW    = 5;
    localparam int RWQ_DW    = 32;
    localparam logic [RWQ_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [RWQ_AW-1:0] r;
        logic [RWQ_DW-1:0] d;
    } rwq_entry_t;
endpackage

// File: rtl/rwq_bypass_match.sv
// Finds the youngest pending queue entry whose destination matches a read index.
module rwq_bypass_match
    import rwq_pkg::*;
#(
    parameter int DEPTH = RWQ_DEPTH,
    parameter int AW    = RWQ_AW,
    parameter int DW    = RWQ_DW,
    localparam int PW   = $clog2(DEPTH)
) (
    input  rwq_entry_t       ent_i [DEPTH],
    input  logic [PW-1:0]    head_i,
    input  logic [PW:0]      count_i,
    input  logic [AW-1:0]    rd_i,
    output logic             hit_o,
    output logic [DW-1:0]    data_o
);
    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later match overrides: the result is the entry nearest tail.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = head_i;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PW'(i);
            if ((PW+1)'(i) < count_i && ent_i[idx].r == rd_i && rd_i != REG_ZERO) begin
                hit_o  = 1'b1;
                data_o = ent_i[idx].d;
            end
        end
    end
endmodule

// File: rtl/reg_write_queue.sv
// In-order write queue in front of the register file, with decode-stage bypass lookup.
module reg_write_queue
    import rwq_pkg::*;
#(
    parameter int DEPTH = RWQ_DEPTH,
    parameter int AW    = RWQ_AW,
    parameter int DW    = RWQ_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_r,
    input  logic [DW-1:0] pipe_data,
    input  logic          md_valid,
    input  logic [AW-1:0] md_r,
    input  logic [DW-1:0] md_data,
    output logic          md_ready,
    output logic          RegWrite,
    output logic [AW-1:0] write_r,
    output logic [DW-1:0] write_data,
    input  logic [AW-1:0] read_r1,
    input  logic [AW-1:0] read_r2,
    output logic          byp_hit1,
    output logic          byp_hit2,
    output logic [DW-1:0] byp_d1,
    output logic [DW-1:0] byp_d2,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, md_idx;
    logic [CW-1:0] count_q, count_d;
    rwq_entry_t    ent_q [DEPTH];
    logic          pop, pipe_push, md_push;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign md_ready  = !rst && !full;
    assign pop       = !empty;
    // Writes to r0 are dropped here, but the md handshake still completes via md_ready.
    assign pipe_push = !rst && pipe_we && (pipe_r != REG_ZERO);
    assign md_push   = md_valid && md_ready && (md_r != REG_ZERO);
    assign md_idx    = tail_q + PW'(pipe_push);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q + PW'(pipe_push) + PW'(md_push);
        count_d = count_q - CW'(pop) + CW'(pipe_push) + CW'(md_push);
        if (pop) begin
            head_d = head_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pipe_push) begin
            ent_q[tail_q] <= '{r: pipe_r, d: pipe_data};
        end
        if (md_push) begin
            ent_q[md_idx] <= '{r: md_r, d: md_data};
        end
    end

    assign RegWrite   = pop;
    assign write_r    = pop ? ent_q[head_q].r : '0;
    assign write_data = pop ? ent_q[head_q].d : '0;

    rwq_bypass_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp1 (
        .ent_i  (ent_q),
        .head_i (head_q),
        .count_i(count_q),
        .rd_i   (read_r1),
        .hit_o  (byp_hit1),
        .data_o (byp_d1)
    );

    rwq_bypass_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp2 (
        .ent_i  (ent_q),
        .head_i (head_q),
        .count_i(count_q),
        .rd_i   (read_r2),
        .hit_o  (byp_hit2),
        .data_o (byp_d2)
    );
endmodule

// File: tb/tb_reg_write_queue.sv
// Randomized and directed bench for reg_write_queue against a queue-based reference model.
module tb_reg_write_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we, md_valid;
    logic [4:0]  pipe_r, md_r, read_r1, read_r2;
    logic [31:0] pipe_data, md_data;
    logic        md_ready, RegWrite, byp_hit1, byp_hit2, empty, full;
    logic [4:0]  write_r;
    logic [31:0] write_data, byp_d1, byp_d2;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    reg_write_queue dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_r(pipe_r), .pipe_data(pipe_data),
        .md_valid(md_valid), .md_r(md_r), .md_data(md_data), .md_ready(md_ready),
        .RegWrite(RegWrite), .write_r(write_r), .write_data(write_data),
        .read_r1(read_r1), .read_r2(read_r2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_d1(byp_d1), .byp_d2(byp_d2),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Youngest matching pending write, scanning from the back of the queue.
    task automatic model_byp(input logic [4:0] rd, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (rd != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].r == rd) begin
                    hit = 1'b1;
                    d   = q[i].d;
                    break;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic pw, input logic [4:0] pr, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mr, input logic [31:0] mdd,
                        input logic [4:0] r1, input logic [4:0] r2);
        logic        exp_ready, h1, h2;
        logic [31:0] d1, d2;
        rst = r; pipe_we = pw; pipe_r = pr; pipe_data = pd;
        md_valid = mv; md_r = mr; md_data = mdd; read_r1 = r1; read_r2 = r2;
        @(negedge clk);
        exp_ready = !r && (q.size() != DEPTH);
        model_byp(r1, h1, d1);
        model_byp(r2, h2, d2);
        chk("md_ready", 32'(md_ready), 32'(exp_ready));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("RegWrite", 32'(RegWrite), 32'(q.size() != 0));
        chk("write_r", 32'(write_r), (q.size() != 0) ? 32'(q[0].r) : 32'd0);
        chk("write_data", write_data, (q.size() != 0) ? q[0].d : 32'd0);
        chk("byp_hit1", 32'(byp_hit1), 32'(h1));
        chk("byp_d1", byp_d1, d1);
        chk("byp_hit2", 32'(byp_hit2), 32'(h2));
        chk("byp_d2", byp_d2, d2);
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (q.size() != 0) void'(q.pop_front());
            if (pw && pr != 5'd0) q.push_back('{r: pr, d: pd});
            if (mv && exp_ready && mr != 5'd0) q.push_back('{r: mr, d: mdd});
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd5);
    endtask

    initial begin
        rst = 1'b1; pipe_we = 1'b0; pipe_r = '0; pipe_data = '0;
        md_valid = 1'b0; md_r = '0; md_data = '0; read_r1 = '0; read_r2 = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd0);

        // single write then drain
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle(2);

        // four cycles of dual pushes, then drain
        for (int i = 1; i <= 4; i++)
            step(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'(10 + i), 32'h200 + 32'(i), 5'd1, 5'd12);
        idle(6);

        // same register twice: bypass must return the younger value
        step(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        idle(2);

        // md write to r0 consumed without enqueue
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD, 5'd0, 5'd0);
        idle(1);

        // build backlog, then reset with md_valid high
        step(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33, 5'd2, 5'd3);
        step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 5'd4, 5'd6);
        step(1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 5'd4, 5'd6);
        idle(2);

        for (int c = 0; c < 3000; c++) begin
            int dens;
            dens = (c / 200) % 4;
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 3) < dens + 1),
                 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) < dens + 1),
                 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
